mc_arb_act_rr: RTL and testbench

- Four-slot round-robin arbiter that chooses which group-FSM activate request is issued next.
- Sits directly upstream of the activate/precharge command mux: its registered one-hot `sel` drives the mux select, which then steers bank/group/rank/row of the winner.
- Enforces tRRD_S, tRRD_L and tFAW spacing between accepted activates, so the mux is only ever pointed at a legal command.

---
 rtl/mc_act_pkg.sv | 28 ++
 rtl/mc_act_faw_track.sv | 42 ++++
 rtl/mc_arb_act_rr.sv | 95 +++++++++
 tb/tb_mc_arb_act_rr.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_act_pkg.sv
// mc_act_pkg: shared types, constants and round-robin pick for the activate arbiter
package mc_act_pkg;
    localparam int NUM_SLOTS   = 4;
    localparam int ACT_PER_FAW = 4;

    typedef logic [NUM_SLOTS-1:0] slot_oh_t;
    typedef logic [1:0]           bgrp_t;

    // One-hot pick of the first eligible slot at or after the one-hot pointer,
    // wrapping 3->0. Scanning from the far end lets the nearest slot win.
    function automatic slot_oh_t rr_pick(input slot_oh_t elig, input slot_oh_t ptr);
        slot_oh_t   pick;
        logic [1:0] start;
        logic [1:0] idx;
        pick  = '0;
        start = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (ptr[i]) start = 2'(i);
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (elig[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/mc_act_faw_track.sv
// mc_act_faw_track: four rolling tFAW timers, faw_ok while any timer has expired
//   clk, rst_n : fabric clock, async active-low reset
//   accept     : an activate was issued this cycle
//   faw_ok     : at least one of the last four activates is outside the window
module mc_act_faw_track
    import mc_act_pkg::*;
#(
    parameter int FAW  = 16,
    parameter int CNTW = $clog2(FAW + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic faw_ok
);
    logic [CNTW-1:0]        tmr [ACT_PER_FAW];
    logic [ACT_PER_FAW-1:0] idle;
    logic [ACT_PER_FAW-1:0] load;

    // The arbiter only selects while a timer is idle and timers only count
    // down until accept, so an accept always finds a free timer.
    always_comb begin
        load = '0;
        for (int i = 0; i < ACT_PER_FAW; i++)
            idle[i] = (tmr[i] == '0);
        for (int i = ACT_PER_FAW - 1; i >= 0; i--)
            if (idle[i]) begin
                load    = '0;
                load[i] = 1'b1;
            end
        faw_ok = |idle;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < ACT_PER_FAW; i++)
                tmr[i] <= '0;
        else
            for (int i = 0; i < ACT_PER_FAW; i++)
                tmr[i] <= (accept && load[i]) ? CNTW'(FAW - 1) :
                          idle[i] ? tmr[i] : tmr[i] - CNTW'(1);
endmodule

// File: rtl/mc_arb_act_rr.sv
// mc_arb_act_rr: 4-slot round-robin activate arbiter with tRRD_S/tRRD_L/tFAW spacing
//   clk, rst_n : fabric clock, async active-low reset
//   req        : per-slot activate request, held until accepted
//   reqGroup   : bank group per slot, slot i in [2i+1:2i]
//   block      : inhibit new selections
//   winAccept  : downstream issued the selected activate this cycle
//   sel        : registered one-hot winner (mux select)
//   selValid   : sel is a legal pending activate
//   selGroup   : bank group of the registered winner
module mc_arb_act_rr
    import mc_act_pkg::*;
#(
    parameter int RRD_S = 4,
    parameter int RRD_L = 6,
    parameter int FAW   = 16,
    parameter int CNTW  = $clog2(FAW + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] reqGroup,
    input  logic       block,
    input  logic       winAccept,
    output logic [3:0] sel,
    output logic       selValid,
    output logic [1:0] selGroup
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]      state;
    slot_oh_t        ptr;
    slot_oh_t        elig;
    slot_oh_t        pick;
    bgrp_t           pick_group;
    bgrp_t           last_group;
    logic            have_act;
    logic            faw_ok;
    logic            accept;
    logic [CNTW-1:0] rrd_cnt;

    assign selValid = (state == HOLD);
    assign accept   = selValid & winAccept;

    always_comb begin
        pick_group = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            elig[i] = req[i] & faw_ok & (!have_act ||
                      rrd_cnt >= ((reqGroup[2*i +: 2] == last_group) ? CNTW'(RRD_L) : CNTW'(RRD_S)));
        pick = rr_pick(elig, ptr);
        for (int i = 0; i < NUM_SLOTS; i++)
            if (pick[i]) pick_group = reqGroup[2*i +: 2];
    end

    // Selection happens only from IDLE, so the accept cycle never reselects
    // and the spacing counters are always fresh when a pick is registered.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            selGroup   <= '0;
            ptr        <= 4'b0001;
            have_act   <= 1'b0;
            last_group <= '0;
            rrd_cnt    <= CNTW'(RRD_L);
        end else begin
            rrd_cnt <= accept ? CNTW'(1) :
                       (rrd_cnt < CNTW'(RRD_L)) ? rrd_cnt + CNTW'(1) : rrd_cnt;
            if (accept) begin
                state      <= IDLE;
                sel        <= '0;
                ptr        <= {sel[2:0], sel[3]};
                last_group <= selGroup;
                have_act   <= 1'b1;
            end else if (state == HOLD && !(|(req & sel))) begin
                state <= IDLE;
                sel   <= '0;
            end else if (state == IDLE && !block && |elig) begin
                state    <= HOLD;
                sel      <= pick;
                selGroup <= pick_group;
            end
        end

    mc_act_faw_track #(.FAW(FAW), .CNTW(CNTW)) u_faw (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .faw_ok (faw_ok)
    );

    a_accept_needs_sel: assert property (@(posedge clk) disable iff (!rst_n) winAccept |-> selValid);
    a_sel_onehot:       assert property (@(posedge clk) disable iff (!rst_n)
                                         $onehot0(sel) && (selValid || sel == '0));
endmodule

// File: tb/tb_mc_arb_act_rr.sv
// tb_mc_arb_act_rr: directed self-checking bench for mc_arb_act_rr
module tb_mc_arb_act_rr;
    localparam int RRD_S = 4;
    localparam int RRD_L = 6;
    localparam int FAW   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] reqGroup = '0;
    logic       block = 1'b0;
    logic       winAccept = 1'b0;
    logic [3:0] sel;
    logic       selValid;
    logic [1:0] selGroup;
    int         total = 0;
    int         bad = 0;
    int         k;

    always #5 clk = ~clk;

    mc_arb_act_rr #(.RRD_S(RRD_S), .RRD_L(RRD_L), .FAW(FAW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .reqGroup  (reqGroup),
        .block     (block),
        .winAccept (winAccept),
        .sel       (sel),
        .selValid  (selValid),
        .selGroup  (selGroup)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick;
    endtask

    task automatic wait_valid(input int lim, output int cyc);
        cyc = 0;
        while (cyc <= lim) begin
            tick;
            cyc++;
            if (selValid) break;
        end
    endtask

    task automatic accept;
        winAccept = 1'b1;
        tick;
        winAccept = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        total++; if (sel !== 4'b0000) begin bad++; $display("FAIL reset_sel got=%b want=0000", sel); end
        total++; if (selValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", selValid); end
        total++; if (selGroup !== 2'd0) begin bad++; $display("FAIL reset_group got=%0d want=0", selGroup); end
        rst_n = 1'b1;
        idle(2);
        total++; if (selValid !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b want=0", selValid); end
    endtask

    task automatic test_rotation;
        req = 4'b1111;
        reqGroup = 8'h00;
        wait_valid(4, k);
        total++; if (k !== 1) begin bad++; $display("FAIL rot_first_lat got=%0d want=1", k); end
        total++; if (sel !== 4'b0001) begin bad++; $display("FAIL rot_first_sel got=%b want=0001", sel); end
        accept;
        total++; if (selValid !== 1'b0) begin bad++; $display("FAIL rot_accept_drop got=%b want=0", selValid); end
        wait_valid(12, k);
        total++; if (k !== RRD_L) begin bad++; $display("FAIL rot_rrdl_lat1 got=%0d want=%0d", k, RRD_L); end
        total++; if (sel !== 4'b0010) begin bad++; $display("FAIL rot_sel1 got=%b want=0010", sel); end
        accept;
        wait_valid(12, k);
        total++; if (k !== RRD_L) begin bad++; $display("FAIL rot_rrdl_lat2 got=%0d want=%0d", k, RRD_L); end
        total++; if (sel !== 4'b0100) begin bad++; $display("FAIL rot_sel2 got=%b want=0100", sel); end
        accept;
        wait_valid(12, k);
        total++; if (k !== RRD_L) begin bad++; $display("FAIL rot_rrdl_lat3 got=%0d want=%0d", k, RRD_L); end
        total++; if (sel !== 4'b1000) begin bad++; $display("FAIL rot_sel3 got=%b want=1000", sel); end
        accept;
        req = 4'b0000;
    endtask

    task automatic test_rrd;
        idle(25);
        req = 4'b0011;
        reqGroup = 8'b00_00_01_00;
        wait_valid(4, k);
        total++; if (sel !== 4'b0001) begin bad++; $display("FAIL rrds_first_sel got=%b want=0001", sel); end
        accept;
        req = 4'b0010;
        wait_valid(12, k);
        total++; if (k !== RRD_S) begin bad++; $display("FAIL rrds_lat got=%0d want=%0d", k, RRD_S); end
        total++; if (sel !== 4'b0010) begin bad++; $display("FAIL rrds_sel got=%b want=0010", sel); end
        total++; if (selGroup !== 2'd1) begin bad++; $display("FAIL rrds_group got=%0d want=1", selGroup); end
        accept;
        req = 4'b0000;
        idle(25);
        req = 4'b0011;
        reqGroup = 8'h00;
        wait_valid(4, k);
        total++; if (k !== 1) begin bad++; $display("FAIL rrdl_first_lat got=%0d want=1", k); end
        total++; if (sel !== 4'b0001) begin bad++; $display("FAIL rrdl_first_sel got=%b want=0001", sel); end
        accept;
        req = 4'b0010;
        wait_valid(12, k);
        total++; if (k !== RRD_L) begin bad++; $display("FAIL rrdl_lat got=%0d want=%0d", k, RRD_L); end
        total++; if (sel !== 4'b0010) begin bad++; $display("FAIL rrdl_sel got=%b want=0010", sel); end
        accept;
        req = 4'b0000;
    endtask

    task automatic test_faw;
        idle(25);
        reqGroup = 8'b11_10_01_00;
        req = 4'b0100;
        wait_valid(4, k);
        total++; if (k !== 1) begin bad++; $display("FAIL faw_first_lat got=%0d want=1", k); end
        accept;
        req = 4'b1000;
        wait_valid(12, k);
        total++; if (k !== RRD_S) begin bad++; $display("FAIL faw_act2_lat got=%0d want=%0d", k, RRD_S); end
        accept;
        req = 4'b0001;
        wait_valid(12, k);
        total++; if (k !== RRD_S) begin bad++; $display("FAIL faw_act3_lat got=%0d want=%0d", k, RRD_S); end
        accept;
        req = 4'b0010;
        wait_valid(12, k);
        total++; if (k !== RRD_S) begin bad++; $display("FAIL faw_act4_lat got=%0d want=%0d", k, RRD_S); end
        accept;
        req = 4'b0100;
        wait_valid(30, k);
        total++; if (k !== FAW - 3 * (RRD_S + 1)) begin bad++; $display("FAIL faw_act5_lat got=%0d want=%0d", k, FAW - 3 * (RRD_S + 1)); end
        total++; if (sel !== 4'b0100) begin bad++; $display("FAIL faw_act5_sel got=%b want=0100", sel); end
        accept;
        req = 4'b0000;
    endtask

    task automatic test_withdraw;
        idle(25);
        req = 4'b0010;
        wait_valid(4, k);
        accept;
        req = 4'b0000;
        idle(8);
        req = 4'b0100;
        wait_valid(4, k);
        total++; if (sel !== 4'b0100) begin bad++; $display("FAIL wd_held_sel got=%b want=0100", sel); end
        req = 4'b0000;
        tick;
        total++; if (selValid !== 1'b0) begin bad++; $display("FAIL wd_valid got=%b want=0", selValid); end
        total++; if (sel !== 4'b0000) begin bad++; $display("FAIL wd_sel_zero got=%b want=0000", sel); end
        req = 4'b0110;
        wait_valid(4, k);
        total++; if (k !== 1) begin bad++; $display("FAIL wd_reselect_lat got=%0d want=1", k); end
        total++; if (sel !== 4'b0100) begin bad++; $display("FAIL wd_reselect_sel got=%b want=0100", sel); end
        accept;
        req = 4'b0000;
    endtask

    task automatic test_block;
        idle(25);
        block = 1'b1;
        req = 4'b0001;
        idle(5);
        total++; if (selValid !== 1'b0) begin bad++; $display("FAIL blk_idle_valid got=%b want=0", selValid); end
        block = 1'b0;
        wait_valid(4, k);
        total++; if (k !== 1) begin bad++; $display("FAIL blk_release_lat got=%0d want=1", k); end
        total++; if (sel !== 4'b0001) begin bad++; $display("FAIL blk_release_sel got=%b want=0001", sel); end
        block = 1'b1;
        idle(3);
        total++; if (selValid !== 1'b1) begin bad++; $display("FAIL blk_hold_valid got=%b want=1", selValid); end
        total++; if (sel !== 4'b0001) begin bad++; $display("FAIL blk_hold_sel got=%b want=0001", sel); end
        accept;
        req = 4'b0010;
        idle(8);
        total++; if (selValid !== 1'b0) begin bad++; $display("FAIL blk_pending_valid got=%b want=0", selValid); end
        block = 1'b0;
        wait_valid(4, k);
        total++; if (k !== 1) begin bad++; $display("FAIL blk_second_lat got=%0d want=1", k); end
        total++; if (sel !== 4'b0010) begin bad++; $display("FAIL blk_second_sel got=%b want=0010", sel); end
    endtask

    task automatic test_async_reset;
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (sel !== 4'b0000) begin bad++; $display("FAIL arst_sel got=%b want=0000", sel); end
        total++; if (selValid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", selValid); end
        total++; if (selGroup !== 2'd0) begin bad++; $display("FAIL arst_group got=%0d want=0", selGroup); end
        tick;
        tick;
        rst_n = 1'b1;
        req = 4'b1111;
        reqGroup = 8'h00;
        wait_valid(4, k);
        total++; if (k !== 1) begin bad++; $display("FAIL arst_first_lat got=%0d want=1", k); end
        total++; if (sel !== 4'b0001) begin bad++; $display("FAIL arst_ptr_sel got=%b want=0001", sel); end
        accept;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        wait_valid(8, k);
        total++; if (k !== 1) begin bad++; $display("FAIL arst_spacing_clear_lat got=%0d want=1", k); end
        total++; if (sel !== 4'b0001) begin bad++; $display("FAIL arst_ptr2_sel got=%b want=0001", sel); end
        accept;
        req = 4'b0000;
        idle(2);
    endtask

    initial begin
        test_reset;
        test_rotation;
        test_rrd;
        test_faw;
        test_withdraw;
        test_block;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
